// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bcd_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int BCD_DIGITS      = 4;
  localparam int MAX_VAL_DEFAULT = 9999;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/result bundle between a binary producer and the BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       thou;
  logic [3:0]       hund;
  logic [3:0]       tens;
  logic [3:0]       ones;

  modport master (
    output start, bin,
    input  busy, done, ovf, thou, hund, tens, ones
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, thou, hund, tens, ones
  );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with saturation at MAX_VAL.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int SCR_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] shreg_q,    shreg_d;
  logic [SCR_W-1:0] scratch_q,  scratch_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q,      ovf_d;
  logic [SCR_W-1:0] digits_q,   digits_d;

  logic [SCR_W-1:0] adj;
  logic [SCR_W-1:0] scr_sh;
  logic [WIDTH-1:0] sh_sh;
  logic             carry;
  logic             over;
  logic [WIDTH-1:0] sat;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Saturation keeps carry at 0; folding it into ovf keeps an impossible digit overflow visible.
  assign {carry, scr_sh, sh_sh} = {adj, shreg_q, 1'b0};
  assign over = (bus.bin > MAX_W);
  assign sat  = over ? MAX_W : bus.bin;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d    = sat;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = over;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = sh_sh;
        scratch_d = scr_sh;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          digits_d = scr_sh;
          ovf_d    = ovf_pend_q | carry;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.ovf  = ovf_q;
  assign bus.thou = digits_q[15:12];
  assign bus.hund = digits_q[11:8];
  assign bus.tens = digits_q[7:4];
  assign bus.ones = digits_q[3:0];
endmodule
